// File: rtl/truth_table_sweeper_pkg.sv
// sweep_pkg: shared constants and types for truth_table_sweeper.
//   VEC_W / N_VEC : width and count of input vectors driven to the function unit
//   TMR_W         : width of the settle down-counter
//   sweep_state_e : sequencer state encoding
//   settle_load() : reload value for the settle counter
package sweep_pkg;

    localparam int unsigned VEC_W = 5;
    localparam int unsigned N_VEC = 32;
    localparam int unsigned TMR_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } sweep_state_e;

    // Counter counts down to zero inclusive, so load one less than the hold time.
    function automatic logic [TMR_W-1:0] settle_load(input int unsigned cyc);
        return TMR_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// sweep_settle_timer: loadable 4-bit down-counter timing the settle phase.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i into the counter
//   load_val_i  : reload value (hold cycles - 1)
//   en_i        : count enable (high while the sequencer is settling)
//   expire_o    : high in the enabled cycle where the count has reached zero
module sweep_settle_timer
    import sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all 32 input vectors of a 5-input function unit,
// captures its truth table and compares it with an expected table.
// Optional feature macro: SWEEP_FAIL_IDX_EN (adds fail_idx / fail_vld).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : sweep request, honoured only in IDLE (latches exp_table)
//   abort      : synchronous return to IDLE, no done pulse
//   exp_table  : expected table, bit k = expected output for vector k
//   dut_in     : vector driven to the unit ({A,B,C,D,E}, A = MSB)
//   dut_out    : unit output
//   busy       : sweep in progress (SETTLE/SAMPLE/DONE)
//   done       : one-cycle completion pulse
//   pass       : signature matched the latched table; valid from done
//   signature  : captured table
//   fail_idx   : lowest mismatching vector (SWEEP_FAIL_IDX_EN)
//   fail_vld   : a mismatch was recorded (SWEEP_FAIL_IDX_EN)
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_VEC-1:0] exp_table,
    output logic [VEC_W-1:0] dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef SWEEP_FAIL_IDX_EN
    output logic [N_VEC-1:0] signature,
    output logic [VEC_W-1:0] fail_idx,
    output logic             fail_vld
`else
    output logic [N_VEC-1:0] signature
`endif
);

    localparam logic [TMR_W-1:0] LOAD_VAL = settle_load(SETTLE_CYC);
    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(N_VEC - 1);

    sweep_state_e     state_q, state_d;
    logic [VEC_W-1:0] idx_q, idx_d;
    logic [N_VEC-1:0] sig_q, sig_d;
    logic [N_VEC-1:0] exp_q, exp_d;
    logic             pass_q, pass_d;
`ifdef SWEEP_FAIL_IDX_EN
    logic [VEC_W-1:0] fidx_q, fidx_d;
    logic             fvld_q, fvld_d;
`endif

    logic tmr_load;
    logic tmr_expire;

    sweep_settle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (LOAD_VAL),
        .en_i       (state_q == S_SETTLE),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sig_d    = sig_q;
        exp_d    = exp_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
`ifdef SWEEP_FAIL_IDX_EN
        fidx_d   = fidx_q;
        fvld_d   = fvld_q;
`endif
        if (abort) begin
            // Abort beats everything, including a start in IDLE; partial
            // signature is deliberately left in place.
            if (state_q != S_IDLE) begin
                state_d = S_IDLE;
                pass_d  = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        exp_d    = exp_table;
                        idx_d    = '0;
                        sig_d    = '0;
                        pass_d   = 1'b0;
                        tmr_load = 1'b1;
                        state_d  = S_SETTLE;
`ifdef SWEEP_FAIL_IDX_EN
                        fidx_d   = '0;
                        fvld_d   = 1'b0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (tmr_expire) begin
                        state_d = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    sig_d[idx_q] = dut_out;
`ifdef SWEEP_FAIL_IDX_EN
                    if ((dut_out != exp_q[idx_q]) && !fvld_q) begin
                        fidx_d = idx_q;
                        fvld_d = 1'b1;
                    end
`endif
                    // Last-vector test precedes the increment, so idx never wraps.
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d    = idx_q + VEC_W'(1);
                        tmr_load = 1'b1;
                        state_d  = S_SETTLE;
                    end
                end
                S_DONE: begin
                    pass_d  = (sig_q == exp_q);
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sig_q   <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
`ifdef SWEEP_FAIL_IDX_EN
            fidx_q  <= '0;
            fvld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
`ifdef SWEEP_FAIL_IDX_EN
            fidx_q  <= fidx_d;
            fvld_q  <= fvld_d;
`endif
        end
    end

    // idx doubles as the vector register, so dut_in holds 31 after a sweep.
    assign dut_in    = idx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE) && !abort;
    // Expose the compare result during the done cycle itself; pass_q holds it after.
    assign pass      = done ? (sig_q == exp_q) : pass_q;
    assign signature = sig_q;
`ifdef SWEEP_FAIL_IDX_EN
    assign fail_idx  = fidx_q;
    assign fail_vld  = fvld_q;
`endif

endmodule
